// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, 32 CALC cycles plus one DONE cycle.
// Divide-by-zero and signed overflow skip CALC and complete in the cycle after accept.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [4:0]  rd_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] hi_q, lo_q, b_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q, rd_last_q;
    logic [31:0] res_q;
    logic        neg_q, spec_q;

    // ---------------- accept and operand decode ----------------
    logic        accept;
    logic        is_div, a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf, special;
    logic [31:0] spec_val;

    assign accept = rst_n && (state_q == IDLE) && valid_i && !flush_i &&
                    (opcode_i == 7'b0110011) && (funct7_i == 7'b0000001);

    assign is_div   = funct3_i[2];
    assign a_signed = is_div ? !funct3_i[0]
                             : ((funct3_i[1:0] == 2'b01) || (funct3_i[1:0] == 2'b10));
    assign b_signed = is_div ? !funct3_i[0] : (funct3_i[1:0] == 2'b01);
    assign a_neg    = a_signed && rs1_data_i[31];
    assign b_neg    = b_signed && rs2_data_i[31];
    assign a_mag    = a_neg ? (32'd0 - rs1_data_i) : rs1_data_i;
    assign b_mag    = b_neg ? (32'd0 - rs2_data_i) : rs2_data_i;
    // Remainder follows the dividend; everything else follows the product/quotient sign
    assign neg_in   = (is_div && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = is_div && (rs2_data_i == 32'd0);
    assign div_ovf  = is_div && !funct3_i[0] && (rs1_data_i == 32'h8000_0000) &&
                      (rs2_data_i == 32'hFFFF_FFFF);
    assign special  = div_zero || div_ovf;

    always_comb begin
        spec_val = 32'd0;
        if (div_zero)
            spec_val = funct3_i[1] ? rs1_data_i : 32'hFFFF_FFFF;
        else if (div_ovf)
            spec_val = funct3_i[1] ? 32'd0 : 32'h8000_0000;
    end

    // ---------------- iteration step ----------------
    // Multiply: {hi,lo} shifts right, lo holds the remaining multiplier bits.
    // Divide: restoring, hi is the partial remainder, lo shifts dividend out / quotient in.
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic [33:0] div_diff;
    logic [31:0] hi_step, lo_step;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    assign div_sh   = {hi_q, lo_q[31]};
    assign div_diff = {1'b0, div_sh} - {2'b00, b_q};

    always_comb begin
        hi_step = mul_sum[32:1];
        lo_step = {mul_sum[0], lo_q[31:1]};
        if (f3_q[2]) begin
            if (!div_diff[33]) begin
                hi_step = div_diff[31:0];
                lo_step = {lo_q[30:0], 1'b1};
            end else begin
                hi_step = div_sh[31:0];
                lo_step = {lo_q[30:0], 1'b0};
            end
        end
    end

    // ---------------- final result (sign applied in DONE) ----------------
    logic [63:0] prod, prod_s;
    logic [31:0] quot_s, rem_s, final_res;

    assign prod   = {hi_q, lo_q};
    assign prod_s = neg_q ? (64'd0 - prod) : prod;
    assign quot_s = neg_q ? (32'd0 - lo_q) : lo_q;
    assign rem_s  = neg_q ? (32'd0 - hi_q) : hi_q;

    always_comb begin
        final_res = 32'd0;
        if (spec_q)
            final_res = lo_q;
        else begin
            case (f3_q)
                3'b000:                 final_res = prod_s[31:0];
                3'b001, 3'b010, 3'b011: final_res = prod_s[63:32];
                3'b100, 3'b101:         final_res = quot_s;
                default:                final_res = rem_s;
            endcase
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: begin
                if (flush_i)               state_d = IDLE;
                else if (cnt_q == 6'd31)   state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 6'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            b_q       <= 32'd0;
            f3_q      <= 3'd0;
            rd_q      <= 5'd0;
            rd_last_q <= 5'd0;
            res_q     <= 32'd0;
            neg_q     <= 1'b0;
            spec_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    cnt_q  <= 6'd0;
                    hi_q   <= 32'd0;
                    lo_q   <= special ? spec_val : a_mag;
                    b_q    <= b_mag;
                    f3_q   <= funct3_i;
                    rd_q   <= rd_i;
                    neg_q  <= neg_in;
                    spec_q <= special;
                end
                CALC: begin
                    cnt_q <= cnt_q + 6'd1;
                    hi_q  <= hi_step;
                    lo_q  <= lo_step;
                end
                DONE: begin
                    res_q     <= final_res;
                    rd_last_q <= rd_q;
                end
                default: ;
            endcase
        end
    end

    assign valid_o  = (state_q == DONE);
    assign stall_o  = accept || (state_q == CALC);
    assign result_o = valid_o ? final_res : res_q;
    assign rd_o     = valid_o ? rd_q : rd_last_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: normal/special latency, signed corner cases, flush and mid-op reset.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [4:0]  rd_i;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic [6:0]  opcode_i, funct7_i;
    logic [2:0]  funct3_i;
    logic        flush_i;
    logic        stall_o, valid_o;
    logic [4:0]  rd_o;
    logic [31:0] result_o;

    int n_tests = 0;
    int n_fail  = 0;

    ex_muldiv dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .rd_i(rd_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .opcode_i(opcode_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .flush_i(flush_i),
        .stall_o(stall_o), .valid_o(valid_o), .rd_o(rd_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [6:0] f7);
        valid_i    = 1'b1;
        opcode_i   = 7'b0110011;
        funct7_i   = f7;
        funct3_i   = f3;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_i       = rd;
    endtask

    task automatic scramble();
        valid_i    = 1'b0;
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
        rd_i       = 5'($urandom);
        funct3_i   = 3'($urandom);
    endtask

    // Issue one op at a negedge; cycle 0 is the accept cycle. Checks latency, stall, rd, result and hold.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_cyc);
        int  cyc;
        bit  stall_ok;
        bit  seen;
        @(negedge clk);
        present(f3, a, b, rd, 7'b0000001);
        #1 check({tag, ".stall0"}, {31'd0, stall_o}, 32'd1);
        @(negedge clk);
        scramble();
        cyc      = 1;
        stall_ok = 1'b1;
        seen     = 1'b0;
        while (cyc <= 40) begin
            if (valid_o) begin
                seen = 1'b1;
                break;
            end
            if (!stall_o) stall_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({tag, ".seen"},  {31'd0, seen}, 32'd1);
        check({tag, ".cycle"}, cyc, exp_cyc);
        check({tag, ".stall"}, {31'd0, stall_ok}, 32'd1);
        check({tag, ".done_stall"}, {31'd0, stall_o}, 32'd0);
        check({tag, ".rd"}, {27'd0, rd_o}, {27'd0, rd});
        check({tag, ".res"}, result_o, exp_res);
        @(negedge clk);
        check({tag, ".pulse"}, {31'd0, valid_o}, 32'd0);
        check({tag, ".hold"}, result_o, exp_res);
    endtask

    initial begin
        int quiet;
        rst_n      = 1'b0;
        valid_i    = 1'b0;
        flush_i    = 1'b0;
        rd_i       = 5'd0;
        rs1_data_i = 32'd0;
        rs2_data_i = 32'd0;
        opcode_i   = 7'd0;
        funct3_i   = 3'd0;
        funct7_i   = 7'd0;
        #12;
        check("rst.valid",  {31'd0, valid_o}, 32'd0);
        check("rst.stall",  {31'd0, stall_o}, 32'd0);
        check("rst.rd",     {27'd0, rd_o},    32'd0);
        check("rst.result", result_o,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul",       3'b000, 32'd7,         32'd6,         5'd5,  32'd42,        33);
        run_op("mulh_m1",   3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd1,  32'd0,         33);
        run_op("mulhu_m1",  3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd2,  32'hFFFFFFFE,  33);
        run_op("mulhsu",    3'b010, 32'hFFFFFFFF,  32'd2,         5'd3,  32'hFFFFFFFF,  33);
        run_op("mulh_min",  3'b001, 32'h80000000,  32'h80000000,  5'd4,  32'h40000000,  33);
        run_op("div_neg",   3'b100, 32'hFFFFFFF9,  32'd2,         5'd6,  32'hFFFFFFFD,  33);
        run_op("rem_neg",   3'b110, 32'hFFFFFFF9,  32'd2,         5'd7,  32'hFFFFFFFF,  33);
        run_op("divu",      3'b101, 32'd100,       32'd7,         5'd8,  32'd14,        33);
        run_op("remu",      3'b111, 32'd100,       32'd7,         5'd9,  32'd2,         33);
        run_op("div_z",     3'b100, 32'd5,         32'd0,         5'd10, 32'hFFFFFFFF,  1);
        run_op("rem_z",     3'b110, 32'd5,         32'd0,         5'd11, 32'd5,         1);
        run_op("div_ovf",   3'b100, 32'h80000000,  32'hFFFFFFFF,  5'd12, 32'h80000000,  1);
        run_op("rem_ovf",   3'b110, 32'h80000000,  32'hFFFFFFFF,  5'd13, 32'd0,         1);

        // Flush in CALC at cycle 10
        @(negedge clk);
        present(3'b101, 32'd1000, 32'd3, 5'd14, 7'b0000001);
        @(negedge clk);
        scramble();
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush.stall", {31'd0, stall_o}, 32'd0);
        quiet = 0;
        repeat (40) begin
            if (valid_o) quiet++;
            @(negedge clk);
        end
        check("flush.no_valid", quiet, 0);
        run_op("after_flush", 3'b000, 32'd123, 32'd3, 5'd15, 32'd369, 33);

        // Reset at cycle 15 of a MUL
        @(negedge clk);
        present(3'b000, 32'd9, 32'd9, 5'd16, 7'b0000001);
        @(negedge clk);
        scramble();
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst.stall",  {31'd0, stall_o}, 32'd0);
        check("arst.valid",  {31'd0, valid_o}, 32'd0);
        check("arst.rd",     {27'd0, rd_o},    32'd0);
        check("arst.result", result_o,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        repeat (40) begin
            if (valid_o) quiet++;
            @(negedge clk);
        end
        check("arst.no_valid", quiet, 0);

        // ADD (funct7=0) must be ignored
        present(3'b000, 32'd1, 32'd2, 5'd17, 7'b0000000);
        #1 check("add.stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        scramble();
        quiet = 0;
        repeat (40) begin
            if (valid_o || stall_o) quiet++;
            @(negedge clk);
        end
        check("add.ignored", quiet, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
